// File: rtl/pll_speed_pkg.sv
// Shared definitions for the PLL speed controller: FSM states, the PLL
// reconfiguration register map and the C0 output-counter preset table.
package pll_speed_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MODE,
        ST_CNT,
        ST_START,
        ST_POLL,
        ST_LOCK
    } state_t;

    localparam logic [5:0] REG_MODE   = 6'h00;
    localparam logic [5:0] REG_STATUS = 6'h01;
    localparam logic [5:0] REG_START  = 6'h02;
    localparam logic [5:0] REG_CNTC   = 6'h05;

    // VCO is 1080 MHz; C0 divides by 12/18/24/36 for 90/60/45/30 MHz.
    // All divisors are even, so odd=0 and high=low=div/2, counter select 0.
    function automatic logic [31:0] c0_word(input logic [1:0] sel);
        case (sel)
            2'd0:    c0_word = 32'h0000_0606;
            2'd1:    c0_word = 32'h0000_0909;
            2'd2:    c0_word = 32'h0000_0C0C;
            default: c0_word = 32'h0000_1212;
        endcase
    endfunction

endpackage

// File: rtl/pll_lock_filter.sv
// Lock qualifier: synchronises the asynchronous PLL lock flag and reports
// stable once it has been high for LOCK_STABLE consecutive clk cycles.
module pll_lock_filter #(
    parameter int LOCK_STABLE = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic lock_async,
    input  logic restart,
    output logic stable
);
    localparam int CW = $clog2(LOCK_STABLE + 1);
    localparam logic [CW-1:0] STABLE_N = CW'(LOCK_STABLE);

    logic          lk_m;
    logic          lk_s;
    logic [CW-1:0] cnt;

    // Two-flop synchroniser for the PLL lock flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lk_m <= 1'b0;
            lk_s <= 1'b0;
        end else begin
            lk_m <= lock_async;
            lk_s <= lk_m;
        end
    end

    // Count consecutive high cycles, saturating; any drop or restart clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!lk_s || restart) begin
            cnt <= '0;
        end else if (cnt != STABLE_N) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Gated with lk_s so a lock loss is seen without waiting for the count to clear
    assign stable = lk_s && (cnt == STABLE_N);

endmodule

// File: rtl/pll_speed_ctrl.sv
// CPU clock speed controller: reprograms PLL counter C0 through the
// reconfiguration Avalon-MM slave and qualifies lock before cpu_clk_ok.
module pll_speed_ctrl
    import pll_speed_pkg::*;
#(
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 1000000,
    parameter int POLL_LIMIT   = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  speed_sel,
    input  logic        pll_locked,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic        mgmt_read,
    output logic [31:0] mgmt_writedata,
    input  logic [31:0] mgmt_readdata,
    input  logic        mgmt_waitrequest,
    output logic        busy,
    output logic        cpu_clk_ok,
    output logic        error
);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int PW = $clog2(POLL_LIMIT + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT - 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_LIMIT - 1);

    state_t        state, state_d;
    logic [1:0]    sel_q, sel_q_d;
    logic [1:0]    cur_sel, cur_sel_d;
    logic          pend, pend_d;
    logic          busy_d, cpu_clk_ok_d, error_d;
    logic [5:0]    addr_d;
    logic          wr_d, rd_d;
    logic [31:0]   wdata_d;
    logic [PW-1:0] poll_cnt, poll_cnt_d;
    logic [TW-1:0] tmo_cnt, tmo_cnt_d;
    logic          stable, restart, wr_acc, rd_acc;
    logic          unused_rdata;

    assign wr_acc       = mgmt_write && !mgmt_waitrequest;
    assign rd_acc       = mgmt_read && !mgmt_waitrequest;
    assign unused_rdata = ^mgmt_readdata[31:1];
    // Hold the lock count at zero until the FSM is actually waiting for lock
    assign restart      = (state != ST_IDLE) && (state != ST_LOCK);

    pll_lock_filter #(
        .LOCK_STABLE(LOCK_STABLE)
    ) u_lock_filter (
        .clk        (clk),
        .rst_n      (rst_n),
        .lock_async (pll_locked),
        .restart    (restart),
        .stable     (stable)
    );

    // Next-state and registered-output logic; each bus state issues one transfer
    always_comb begin
        state_d      = state;
        sel_q_d      = sel_q;
        cur_sel_d    = cur_sel;
        pend_d       = pend;
        busy_d       = busy;
        cpu_clk_ok_d = cpu_clk_ok;
        error_d      = error;
        addr_d       = mgmt_address;
        wr_d         = mgmt_write;
        rd_d         = mgmt_read;
        wdata_d      = mgmt_writedata;
        poll_cnt_d   = poll_cnt;
        tmo_cnt_d    = tmo_cnt;
        case (state)
            ST_IDLE: begin
                if (pend || (speed_sel != cur_sel)) begin
                    state_d      = ST_MODE;
                    sel_q_d      = speed_sel;
                    pend_d       = 1'b0;
                    error_d      = 1'b0;
                    busy_d       = 1'b1;
                    cpu_clk_ok_d = 1'b0;
                    poll_cnt_d   = '0;
                    tmo_cnt_d    = '0;
                end else begin
                    cpu_clk_ok_d = stable && !error;
                end
            end
            ST_MODE: begin
                if (!mgmt_write) begin
                    wr_d    = 1'b1;
                    addr_d  = REG_MODE;
                    wdata_d = 32'd1;
                end else if (wr_acc) begin
                    wr_d    = 1'b0;
                    state_d = ST_CNT;
                end
            end
            ST_CNT: begin
                if (!mgmt_write) begin
                    wr_d    = 1'b1;
                    addr_d  = REG_CNTC;
                    wdata_d = c0_word(sel_q);
                end else if (wr_acc) begin
                    wr_d    = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (!mgmt_write) begin
                    wr_d    = 1'b1;
                    addr_d  = REG_START;
                    wdata_d = 32'd1;
                end else if (wr_acc) begin
                    wr_d    = 1'b0;
                    state_d = ST_POLL;
                end
            end
            ST_POLL: begin
                // The cycle the strobe is low after a not-done read is the idle gap
                if (!mgmt_read) begin
                    rd_d    = 1'b1;
                    addr_d  = REG_STATUS;
                    wdata_d = 32'd0;
                end else if (rd_acc) begin
                    rd_d = 1'b0;
                    if (mgmt_readdata[0]) begin
                        state_d   = ST_LOCK;
                        tmo_cnt_d = '0;
                    end else if (poll_cnt == POLL_LAST) begin
                        state_d   = ST_IDLE;
                        error_d   = 1'b1;
                        busy_d    = 1'b0;
                        cur_sel_d = sel_q;
                    end else begin
                        poll_cnt_d = poll_cnt + 1'b1;
                    end
                end
            end
            ST_LOCK: begin
                if (stable) begin
                    state_d      = ST_IDLE;
                    cpu_clk_ok_d = 1'b1;
                    busy_d       = 1'b0;
                    cur_sel_d    = sel_q;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_d   = ST_IDLE;
                    error_d   = 1'b1;
                    busy_d    = 1'b0;
                    cur_sel_d = sel_q;
                end else begin
                    tmo_cnt_d = tmo_cnt + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset abandons any bus cycle and requests a reprogram
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            sel_q          <= 2'd0;
            cur_sel        <= 2'd0;
            pend           <= 1'b1;
            busy           <= 1'b0;
            cpu_clk_ok     <= 1'b0;
            error          <= 1'b0;
            mgmt_address   <= 6'd0;
            mgmt_write     <= 1'b0;
            mgmt_read      <= 1'b0;
            mgmt_writedata <= 32'd0;
            poll_cnt       <= '0;
            tmo_cnt        <= '0;
        end else begin
            state          <= state_d;
            sel_q          <= sel_q_d;
            cur_sel        <= cur_sel_d;
            pend           <= pend_d;
            busy           <= busy_d;
            cpu_clk_ok     <= cpu_clk_ok_d;
            error          <= error_d;
            mgmt_address   <= addr_d;
            mgmt_write     <= wr_d;
            mgmt_read      <= rd_d;
            mgmt_writedata <= wdata_d;
            poll_cnt       <= poll_cnt_d;
            tmo_cnt        <= tmo_cnt_d;
        end
    end

endmodule

// File: tb/tb_pll_speed_ctrl.sv
// Testbench for pll_speed_ctrl: Avalon slave + PLL behavioural model,
// randomized speed changes and wait states, transaction-level scoreboard.
module tb_pll_speed_ctrl;
    localparam int L = 16;
    localparam int T = 300;
    localparam int P = 8;

    typedef struct packed {
        logic        rd;
        logic [5:0]  a;
        logic [31:0] d;
    } xfer_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  speed_sel;
    logic        pll_locked;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic        mgmt_read;
    logic [31:0] mgmt_writedata;
    logic [31:0] mgmt_readdata;
    logic        mgmt_waitrequest;
    logic        busy;
    logic        cpu_clk_ok;
    logic        error;

    int    n_checks = 0;
    int    n_errors = 0;
    int    ws = 0;
    int    status_zeros = 0;
    int    poll_reads = 0;
    bit    lock_enable = 1'b1;
    int    cyc = 0;
    int    ok_rise_cyc = 0;
    int    err_rise_cyc = 0;
    int    lock_set_cyc = 0;
    int    status_ok_cyc = 0;
    int    relock_timer = 0;
    xfer_t log_q[$];
    logic [1:0] cur_model;

    pll_speed_ctrl #(
        .LOCK_STABLE  (L),
        .LOCK_TIMEOUT (T),
        .POLL_LIMIT   (P)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .speed_sel        (speed_sel),
        .pll_locked       (pll_locked),
        .mgmt_address     (mgmt_address),
        .mgmt_write       (mgmt_write),
        .mgmt_read        (mgmt_read),
        .mgmt_writedata   (mgmt_writedata),
        .mgmt_readdata    (mgmt_readdata),
        .mgmt_waitrequest (mgmt_waitrequest),
        .busy             (busy),
        .cpu_clk_ok       (cpu_clk_ok),
        .error            (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected C0 word from the CPU frequency: divisor = 1080 / MHz
    function automatic logic [31:0] exp_c0(input logic [1:0] sel);
        int mhz [4] = '{90, 60, 45, 30};
        int div;
        int hi;
        int lo;
        div = 1080 / mhz[sel];
        hi  = (div + 1) / 2;
        lo  = div / 2;
        return 32'(((div % 2) << 17) | (hi << 8) | lo);
    endfunction

    // Avalon slave, PLL lock model and event timestamps, all at the falling edge
    initial begin : slave_model
        bit          in_xfer = 1'b0;
        bit          acc_pend = 1'b0;
        bit          ok_prev = 1'b0;
        bit          err_prev = 1'b0;
        int          wleft = 0;
        xfer_t       cur;
        logic [31:0] rnd;
        mgmt_waitrequest = 1'b0;
        mgmt_readdata    = 32'd0;
        cur              = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (cpu_clk_ok && !ok_prev) ok_rise_cyc = cyc;
            if (error && !err_prev) err_rise_cyc = cyc;
            ok_prev  = cpu_clk_ok;
            err_prev = error;
            if (!rst_n) begin
                in_xfer          = 1'b0;
                acc_pend         = 1'b0;
                mgmt_waitrequest = 1'b0;
            end else begin
                if (acc_pend) begin
                    acc_pend = 1'b0;
                    in_xfer  = 1'b0;
                    log_q.push_back(cur);
                    check_val("strobe_drop", 32'(mgmt_write | mgmt_read), 32'd0);
                    if (!cur.rd && cur.a == 6'h00) poll_reads = 0;
                    if (!cur.rd && cur.a == 6'h02) begin
                        pll_locked   = 1'b0;
                        relock_timer = 0;
                    end
                    if (cur.rd && cur.d[0]) begin
                        status_ok_cyc = cyc;
                        if (lock_enable) relock_timer = int'($urandom_range(10, 4));
                    end
                end else if (mgmt_write || mgmt_read) begin
                    check_val("wr_rd_excl", 32'(mgmt_write & mgmt_read), 32'd0);
                    if (!in_xfer) begin
                        in_xfer = 1'b1;
                        cur     = '{rd: mgmt_read, a: mgmt_address, d: mgmt_writedata};
                        wleft   = ws;
                    end else begin
                        check_val("hold_kind", 32'(mgmt_read), 32'(cur.rd));
                        check_val("hold_addr", 32'(mgmt_address), 32'(cur.a));
                        if (!cur.rd) check_val("hold_data", mgmt_writedata, cur.d);
                    end
                    if (wleft > 0) begin
                        mgmt_waitrequest = 1'b1;
                        wleft--;
                    end else begin
                        mgmt_waitrequest = 1'b0;
                        acc_pend         = 1'b1;
                        if (cur.rd) begin
                            rnd           = $urandom();
                            rnd[0]        = (poll_reads >= status_zeros);
                            poll_reads++;
                            mgmt_readdata = rnd;
                            cur.d         = rnd;
                        end
                    end
                end else begin
                    mgmt_waitrequest = 1'b0;
                end
                if (relock_timer > 0) begin
                    relock_timer--;
                    if (relock_timer == 0) begin
                        pll_locked   = 1'b1;
                        lock_set_cyc = cyc;
                    end
                end
            end
        end
    end

    // Wait for one whole sequence and compare it with the expected transfer list
    task automatic expect_seq(input logic [1:0] sel, input int zeros);
        xfer_t exp_q[$];
        int    t;
        int    nreads;
        bit    poll_fail;
        bit    lock_fail;
        poll_fail = (zeros >= P);
        lock_fail = !poll_fail && !lock_enable;
        nreads    = poll_fail ? P : zeros + 1;
        exp_q.push_back('{rd: 1'b0, a: 6'h00, d: 32'd1});
        exp_q.push_back('{rd: 1'b0, a: 6'h05, d: exp_c0(sel)});
        exp_q.push_back('{rd: 1'b0, a: 6'h02, d: 32'd1});
        for (int i = 0; i < nreads; i++) exp_q.push_back('{rd: 1'b1, a: 6'h01, d: 32'd0});
        t = 0;
        while (!busy && t < 20) begin
            @(negedge clk);
            t++;
        end
        check_val("busy_rise", 32'(busy), 32'd1);
        check_val("start_err_clr", 32'(error), 32'd0);
        check_val("start_ok_clr", 32'(cpu_clk_ok), 32'd0);
        t = 0;
        while (busy && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check_val("busy_fall", 32'(busy), 32'd0);
        check_val("clk_ok_end", 32'(cpu_clk_ok), 32'(!(poll_fail || lock_fail)));
        check_val("error_end", 32'(error), 32'(poll_fail || lock_fail));
        check_val("xfer_count", 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            check_val("xfer_kind", 32'(log_q[i].rd), 32'(exp_q[i].rd));
            check_val("xfer_addr", 32'(log_q[i].a), 32'(exp_q[i].a));
            if (!exp_q[i].rd) check_val("xfer_data", log_q[i].d, exp_q[i].d);
        end
        log_q.delete();
        if (!poll_fail && !lock_fail)
            check_val("lock_to_ok", 32'(ok_rise_cyc - lock_set_cyc), 32'(L + 3));
        if (lock_fail)
            check_val("lock_timeout", 32'(err_rise_cyc - status_ok_cyc), 32'(T));
    endtask

    task automatic program_sel(input logic [1:0] sel, input int zeros);
        status_zeros = zeros;
        speed_sel    = sel;
        expect_seq(sel, zeros);
        cur_model = sel;
    endtask

    function automatic logic [1:0] pick_other(input logic [1:0] cur);
        logic [1:0] s;
        s = 2'($urandom_range(3, 0));
        if (s == cur) s = s + 2'd1;
        return s;
    endfunction

    initial begin : main
        int         t;
        int         fall_k;
        int         rel;
        logic [1:0] s;
        rst_n      = 1'b1;
        speed_sel  = 2'd0;
        pll_locked = 1'b0;
        cur_model  = 2'd0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_ok", 32'(cpu_clk_ok), 32'd0);
        check_val("rst_error", 32'(error), 32'd0);
        check_val("rst_strobes", 32'({mgmt_write, mgmt_read}), 32'd0);
        check_val("rst_addr", 32'(mgmt_address), 32'd0);
        check_val("rst_wdata", mgmt_writedata, 32'd0);
        rst_n = 1'b1;

        // Programming right after reset release
        expect_seq(2'd0, 0);

        // Long wait states on every access
        ws = 5;
        program_sel(pick_other(cur_model), 0);

        // Unchanged selection starts nothing
        ws = 0;
        repeat (8) @(negedge clk);
        check_val("noop_busy", 32'(busy), 32'd0);

        // Random selections, wait states and not-done poll counts
        for (int i = 0; i < 5; i++) begin
            ws = int'($urandom_range(3, 0));
            program_sel(pick_other(cur_model), int'($urandom_range(3, 0)));
        end

        // Three not-done polls, then poll exhaustion with sticky error
        ws = 1;
        program_sel(pick_other(cur_model), 3);
        program_sel(pick_other(cur_model), 100);
        repeat (6) @(negedge clk);
        check_val("err_sticky", 32'(error), 32'd1);
        check_val("err_idle_busy", 32'(busy), 32'd0);

        // Lock never arrives, then the next change recovers
        lock_enable = 1'b0;
        program_sel(pick_other(cur_model), 0);
        check_val("tmo_ok_low", 32'(cpu_clk_ok), 32'd0);
        lock_enable = 1'b1;
        program_sel(pick_other(cur_model), 1);

        // Selection change during status polling
        if (cur_model == 2'd0) program_sel(2'd2, 0);
        status_zeros = 0;
        speed_sel    = 2'd0;
        t = 0;
        while (!mgmt_read && t < 200) begin
            @(negedge clk);
            t++;
        end
        check_val("reach_poll", 32'(mgmt_read), 32'd1);
        speed_sel = 2'd3;
        expect_seq(2'd0, 0);
        expect_seq(2'd3, 0);
        cur_model = 2'd3;

        // One-cycle lock glitch while idle
        repeat (4) @(negedge clk);
        check_val("glitch_pre_ok", 32'(cpu_clk_ok), 32'd1);
        pll_locked = 1'b0;
        fall_k = 0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) pll_locked = 1'b1;
            if (!cpu_clk_ok && fall_k == 0) fall_k = k;
        end
        check_val("glitch_ok_fall", 32'(fall_k != 0), 32'd1);
        rel = 2;
        while (!cpu_clk_ok && rel < L + 20) begin
            @(negedge clk);
            rel++;
        end
        check_val("glitch_relock", 32'(rel), 32'(L + 3));
        check_val("glitch_no_prog", 32'(log_q.size()), 32'd0);
        check_val("glitch_busy", 32'(busy), 32'd0);

        // Reset in the middle of the counter write
        ws = 3;
        s  = pick_other(cur_model);
        speed_sel = s;
        t = 0;
        while (!(mgmt_write && mgmt_address == 6'h05) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check_val("reach_cnt_write", 32'(mgmt_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("rst_strobe_now", 32'({mgmt_write, mgmt_read}), 32'd0);
        check_val("rst_busy_now", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        log_q.delete();
        relock_timer = 0;
        rst_n = 1'b1;
        expect_seq(s, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
